// File: rtl/uart_apb_arbiter.sv
// Two-master round-robin APB3 arbiter in front of the UART register-map slave.
// One transfer at a time, registered outputs, access timeout.
module uart_apb_arbiter #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      i_apb_pclk,
  input  logic                      i_apb_presetn,
  input  logic [APB_ADDR_WIDTH-1:0] i_s0_apb_paddr,
  input  logic [APB_DATA_WIDTH-1:0] i_s0_apb_pwdata,
  input  logic                      i_s0_apb_pwrite,
  input  logic                      i_s0_apb_psel,
  input  logic                      i_s0_apb_penable,
  output logic                      o_s0_apb_pready,
  output logic [APB_DATA_WIDTH-1:0] o_s0_apb_prdata,
  output logic                      o_s0_apb_pslverr,
  input  logic [APB_ADDR_WIDTH-1:0] i_s1_apb_paddr,
  input  logic [APB_DATA_WIDTH-1:0] i_s1_apb_pwdata,
  input  logic                      i_s1_apb_pwrite,
  input  logic                      i_s1_apb_psel,
  input  logic                      i_s1_apb_penable,
  output logic                      o_s1_apb_pready,
  output logic [APB_DATA_WIDTH-1:0] o_s1_apb_prdata,
  output logic                      o_s1_apb_pslverr,
  output logic [APB_ADDR_WIDTH-1:0] o_m_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_m_apb_pwdata,
  output logic                      o_m_apb_pwrite,
  output logic                      o_m_apb_psel,
  output logic                      o_m_apb_penable,
  input  logic                      i_m_apb_pready,
  input  logic [APB_DATA_WIDTH-1:0] i_m_apb_prdata,
  input  logic                      i_m_apb_pslverr,
  output logic                      o_busy,
  output logic                      o_grant
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic                      pick;
  logic                      any_req;
  logic                      done;
  logic                      rsp_err;
  logic [APB_DATA_WIDTH-1:0] rsp_data;

  // Both requesting: the master not served last wins.
  assign any_req = i_s0_apb_psel | i_s1_apb_psel;
  assign pick    = (i_s0_apb_psel & i_s1_apb_psel) ? ~o_grant
                                                   : i_s1_apb_psel;

  // A timed-out access reports an error with zero data.
  assign done     = i_m_apb_pready | (cnt == CNT_LAST);
  assign rsp_err  = i_m_apb_pready ? i_m_apb_pslverr : 1'b1;
  assign rsp_data = (i_m_apb_pready & ~o_m_apb_pwrite)
                  ? i_m_apb_prdata : '0;

  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) begin
      state            <= IDLE;
      cnt              <= '0;
      o_grant          <= 1'b1;
      o_busy           <= 1'b0;
      o_m_apb_paddr    <= '0;
      o_m_apb_pwdata   <= '0;
      o_m_apb_pwrite   <= 1'b0;
      o_m_apb_psel     <= 1'b0;
      o_m_apb_penable  <= 1'b0;
      o_s0_apb_pready  <= 1'b0;
      o_s0_apb_prdata  <= '0;
      o_s0_apb_pslverr <= 1'b0;
      o_s1_apb_pready  <= 1'b0;
      o_s1_apb_prdata  <= '0;
      o_s1_apb_pslverr <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state           <= SETUP;
            cnt             <= '0;
            o_grant         <= pick;
            o_busy          <= 1'b1;
            o_m_apb_psel    <= 1'b1;
            o_m_apb_penable <= 1'b0;
            o_m_apb_paddr   <= pick ? i_s1_apb_paddr : i_s0_apb_paddr;
            o_m_apb_pwdata  <= pick ? i_s1_apb_pwdata : i_s0_apb_pwdata;
            o_m_apb_pwrite  <= pick ? i_s1_apb_pwrite : i_s0_apb_pwrite;
          end
        end
        SETUP: begin
          state           <= ACCESS;
          o_m_apb_penable <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            state           <= RESP;
            o_m_apb_psel    <= 1'b0;
            o_m_apb_penable <= 1'b0;
            if (o_grant) begin
              o_s1_apb_pready  <= 1'b1;
              o_s1_apb_prdata  <= rsp_data;
              o_s1_apb_pslverr <= rsp_err;
            end else begin
              o_s0_apb_pready  <= 1'b1;
              o_s0_apb_prdata  <= rsp_data;
              o_s0_apb_pslverr <= rsp_err;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state            <= IDLE;
          o_busy           <= 1'b0;
          o_s0_apb_pready  <= 1'b0;
          o_s0_apb_prdata  <= '0;
          o_s0_apb_pslverr <= 1'b0;
          o_s1_apb_pready  <= 1'b0;
          o_s1_apb_prdata  <= '0;
          o_s1_apb_pslverr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Randomized bench for uart_apb_arbiter: two APB master drivers, a regmap
// model with address-derived latency/data/error, transaction-level checks.
module tb_uart_apb_arbiter;

  localparam int T    = 16;
  localparam int HANG = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  psel = '0;
  logic [1:0]  penable = '0;
  logic [1:0]  pwrite = '0;
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [1:0]  pready;
  logic [31:0] prdata [2];
  logic [1:0]  pslverr;
  logic [31:0] m_paddr, m_pwdata;
  logic        m_pwrite, m_psel, m_penable;
  logic        m_pready = 1'b0;
  logic [31:0] m_prdata = '0;
  logic        m_pslverr = 1'b0;
  logic        busy, grant;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_setup = 0;
  int n_access = 0;
  bit track = 1'b1;
  bit dual = 1'b0;
  int pr_seen [2];
  bit          pend [2];
  int          served [2];
  logic [31:0] q_addr [2];
  logic [31:0] q_wdata [2];
  logic        q_write [2];
  int          order_q [$];

  uart_apb_arbiter #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_apb_pclk      (clk),
    .i_apb_presetn   (rst_n),
    .i_s0_apb_paddr  (paddr[0]),
    .i_s0_apb_pwdata (pwdata[0]),
    .i_s0_apb_pwrite (pwrite[0]),
    .i_s0_apb_psel   (psel[0]),
    .i_s0_apb_penable(penable[0]),
    .o_s0_apb_pready (pready[0]),
    .o_s0_apb_prdata (prdata[0]),
    .o_s0_apb_pslverr(pslverr[0]),
    .i_s1_apb_paddr  (paddr[1]),
    .i_s1_apb_pwdata (pwdata[1]),
    .i_s1_apb_pwrite (pwrite[1]),
    .i_s1_apb_psel   (psel[1]),
    .i_s1_apb_penable(penable[1]),
    .o_s1_apb_pready (pready[1]),
    .o_s1_apb_prdata (prdata[1]),
    .o_s1_apb_pslverr(pslverr[1]),
    .o_m_apb_paddr   (m_paddr),
    .o_m_apb_pwdata  (m_pwdata),
    .o_m_apb_pwrite  (m_pwrite),
    .o_m_apb_psel    (m_psel),
    .o_m_apb_penable (m_penable),
    .i_m_apb_pready  (m_pready),
    .i_m_apb_prdata  (m_prdata),
    .i_m_apb_pslverr (m_pslverr),
    .o_busy          (busy),
    .o_grant         (grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Regmap model: latency, data and error are pure functions of the access.
  function automatic int dly(input logic [31:0] a);
    if (a[8] && a[7:4] == 4'hF) return HANG;
    return (int'(a[7:4]) + 1) % 16;
  endfunction

  function automatic logic [31:0] rdfun(input logic [31:0] a);
    return 32'hA5A5_0000 ^ {16'h0, a[18:3]};
  endfunction

  function automatic logic errfun(input logic [31:0] a, input logic w);
    return a[3] & w;
  endfunction

  function automatic int exp_lat(input logic [31:0] a);
    int d = dly(a);
    return (d >= T) ? 2 + T : 3 + d;
  endfunction

  initial begin : regmap
    int  acnt;
    bit  in_acc;
    bit  found;
    acnt   = 0;
    in_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (pready[0] && pready[1]) dual = 1'b1;
      if (pready[0]) pr_seen[0]++;
      if (pready[1]) pr_seen[1]++;
      if (m_psel && m_penable) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          acnt   = 0;
          n_access++;
          if (track) begin
            found = 1'b0;
            for (int m = 0; m < 2; m++)
              if (!found && pend[m] && served[m] == 0 &&
                  q_addr[m] == m_paddr && q_write[m] == m_pwrite &&
                  (!m_pwrite || q_wdata[m] == m_pwdata)) begin
                found = 1'b1;
                served[m]++;
              end
            chk("dn_match", 32'(found), 32'd1);
          end
        end
        if (acnt == dly(m_paddr)) begin
          m_pready  = 1'b1;
          m_prdata  = rdfun(m_paddr);
          m_pslverr = errfun(m_paddr, m_pwrite);
        end else begin
          m_pready  = 1'b0;
          m_prdata  = $urandom;
          m_pslverr = 1'($urandom);
        end
        acnt++;
      end else begin
        in_acc = 1'b0;
        if (m_psel) n_setup++;
        m_pready  = 1'($urandom);
        m_prdata  = $urandom;
        m_pslverr = 1'($urandom);
      end
    end
  end

  // One APB transfer from master m; called at posedge+1.
  task automatic xfer(input int m, input logic [31:0] a,
                      input logic [31:0] wd, input logic wr,
                      input int lat_exp);
    int   c0;
    bit   got;
    bit   leak;
    logic [31:0] rd_exp;
    logic        err_exp;
    if (dly(a) >= T) begin
      rd_exp  = '0;
      err_exp = 1'b1;
    end else begin
      rd_exp  = wr ? 32'h0 : rdfun(a);
      err_exp = errfun(a, wr);
    end
    pend[m]    = 1'b1;
    served[m]  = 0;
    q_addr[m]  = a;
    q_wdata[m] = wd;
    q_write[m] = wr;
    c0         = cyc;
    got        = 1'b0;
    leak       = 1'b0;
    paddr[m]   = a;
    pwdata[m]  = wd;
    pwrite[m]  = wr;
    psel[m]    = 1'b1;
    penable[m] = 1'b0;
    @(posedge clk);
    #1 penable[m] = 1'b1;
    while (!got && cyc - c0 < 120) begin
      @(negedge clk);
      if (pready[m]) got = 1'b1;
      else if (prdata[m] != 0 || pslverr[m]) leak = 1'b1;
    end
    chk($sformatf("m%0d_done", m), 32'(got), 32'd1);
    if (got) begin
      order_q.push_back(m);
      chk($sformatf("m%0d_rdata", m), prdata[m], rd_exp);
      chk($sformatf("m%0d_err", m), 32'(pslverr[m]), 32'(err_exp));
      chk($sformatf("m%0d_grant", m), 32'(grant), 32'(m));
      chk($sformatf("m%0d_busy", m), 32'(busy), 32'd1);
      chk($sformatf("m%0d_one_acc", m), 32'(served[m]), 32'd1);
      chk($sformatf("m%0d_quiet", m), 32'(leak), 32'd0);
      if (lat_exp >= 0)
        chk($sformatf("m%0d_lat", m), 32'(cyc - c0), 32'(lat_exp));
    end
    @(posedge clk);
    #1;
    psel[m]    = 1'b0;
    penable[m] = 1'b0;
    pend[m]    = 1'b0;
  endtask

  task automatic rnd_master(input int m);
    logic [31:0] a;
    if ($urandom_range(3) != 0) begin
      repeat ($urandom_range(3)) @(posedge clk);
      if (cyc > 0) #0;
      a = $urandom & 32'h0000_1FFC;
      xfer(m, a, $urandom, 1'($urandom), -1);
    end
  endtask

  initial begin : main
    int s0, a0;
    paddr[0] = '0; paddr[1] = '0;
    pwdata[0] = '0; pwdata[1] = '0;
    pr_seen[0] = 0; pr_seen[1] = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    served[0] = 0; served[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", 32'(m_psel), 32'd0);
    chk("rst_penable", 32'(m_penable), 32'd0);
    chk("rst_paddr", m_paddr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_prdata0", prdata[0], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous requests out of reset alternate s0, s1, s0, s1.
    for (int r = 0; r < 2; r++)
      fork
        xfer(0, 32'h0000_0010 + 32'(r) * 32'h100, 32'h0, 1'b0, -1);
        xfer(1, 32'h0000_0024 + 32'(r) * 32'h100, 32'h0, 1'b0, -1);
      join
    chk("rr_len", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      chk($sformatf("rr_order%0d", i), 32'(order_q[i]), 32'(i % 2));

    // Single s0 read, regmap answers one cycle after PENABLE.
    s0 = n_setup;
    a0 = n_access;
    xfer(0, 32'h0000_0008, 32'h0, 1'b0, 4);
    chk("single_setups", 32'(n_setup - s0), 32'd1);
    chk("single_access", 32'(n_access - a0), 32'd1);

    // s1 arrives while an s0 write is in ACCESS and waits its turn.
    fork
      xfer(0, 32'h0000_0040, 32'h0000_00C3, 1'b1, exp_lat(32'h40));
      begin
        repeat (3) @(posedge clk);
        #1 xfer(1, 32'h0000_0030, 32'h0, 1'b0,
                exp_lat(32'h40) + 1 + exp_lat(32'h30) - 3);
      end
    join

    // Hung regmap times out, next transfer is normal.
    xfer(1, 32'h0000_01F0, 32'h0, 1'b0, exp_lat(32'h1F0));
    xfer(1, 32'h0000_00E0, 32'h0, 1'b0, exp_lat(32'hE0));

    // Slave error on read-only offset, then a clean write.
    xfer(0, 32'h0000_0018, 32'h1234_5678, 1'b1, exp_lat(32'h18));
    xfer(0, 32'h0000_0020, 32'h1234_5678, 1'b1, exp_lat(32'h20));

    // Reset in the middle of ACCESS.
    track = 1'b0;
    pr_seen[0] = 0;
    paddr[0]   = 32'h0000_01F0;
    pwrite[0]  = 1'b0;
    psel[0]    = 1'b1;
    @(posedge clk);
    #1 penable[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(m_psel), 32'd0);
    chk("mid_rst_penable", 32'(m_penable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd1);
    psel[0]    = 1'b0;
    penable[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("mid_rst_no_pready", 32'(pr_seen[0]), 32'd0);
    #1 track = 1'b1;
    xfer(1, 32'h0000_0020, 32'h0, 1'b0, exp_lat(32'h20));

    // Random traffic from both masters.
    for (int i = 0; i < 60; i++)
      fork
        rnd_master(0);
        rnd_master(1);
      join

    chk("never_dual_pready", 32'(dual), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
